// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// countdown_timer: loadable down-counter, one decrement per PRESCALE enabled
// clocks, with tick/done pulses. Optional macro COUNTDOWN_AUTO_RELOAD_EN.
// Revision: 1.0
// ============================================================================
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 50000000
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      count_q  <= '0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    // A load always wins over a tick falling due in the same cycle.
    if (load) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = load_value;
`endif
      count_d = load_value;
      presc_d = '0;
      if (load_value == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN && enable) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (count_q == WIDTH'(1)) begin
          done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          count_d = reload_q;
`else
          count_d = '0;
          state_d = IDLE;
`endif
        end else begin
          count_d = count_q - 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign tick  = tick_q;
  assign done  = done_q;

endmodule
`default_nettype wire
